// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide unit holding the architectural HI/LO
// registers for the MIPS execute stage.
//   - MULT/MULTU: 2*WIDTH-bit product of the latched operands, written to
//     {hi,lo} MUL_CYCLES edges after the request is accepted.
//   - DIV/DIVU: restoring shift-subtract on magnitudes, one quotient bit per
//     cycle, followed by a single sign fix-up cycle.
//   - MTHI/MTLO: single-cycle register writes from operand a.
// Optional macro MULDIV_HILO_BYPASS_EN: hi/lo become combinational forwards of
// the value being written in the write cycle; otherwise they are pure registers.
module muldiv_hilo #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Counter must hold both WIDTH-1 and MUL_CYCLES-1.
    localparam int CNT_W = $clog2(WIDTH + MUL_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic               sgn_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic               div_zero_r;

    logic               issue_s;
    logic               b_zero_s;
    logic               op_mul_s;
    logic               op_div_s;
    logic               acc_mthi_s;
    logic               acc_mtlo_s;
    logic               acc_mul_s;
    logic               acc_div_s;
    logic               acc_dz_s;
    logic               div_sgn_s;
    logic               cnt_zero_s;

    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   q_fix_s;
    logic [WIDTH-1:0]   r_fix_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;

    logic               stall_s;
    logic               wr_s;
    logic [WIDTH-1:0]   wr_hi_s;
    logic [WIDTH-1:0]   wr_lo_s;

    // Decode the issue request; only an idle, unflushed start is accepted.
    always_comb begin
        issue_s    = (state_r == ST_IDLE) & start & ~flush;
        b_zero_s   = (b == ZERO_W);
        op_mul_s   = (op == OP_MULT) | (op == OP_MULTU);
        op_div_s   = (op == OP_DIV)  | (op == OP_DIVU);
        div_sgn_s  = (op == OP_DIV);
        acc_mthi_s = issue_s & (op == OP_MTHI);
        acc_mtlo_s = issue_s & (op == OP_MTLO);
        acc_mul_s  = issue_s & op_mul_s;
        acc_div_s  = issue_s & op_div_s & ~b_zero_s;
        acc_dz_s   = issue_s & op_div_s & b_zero_s;
        cnt_zero_s = (cnt_r == CNT_ZERO);
    end

    // Arithmetic datapath: product, one restoring-division step, sign fix-up.
    always_comb begin
        ext_a_s   = {{WIDTH{sgn_r & opa_r[WIDTH-1]}}, opa_r};
        ext_b_s   = {{WIDTH{sgn_r & opb_r[WIDTH-1]}}, opb_r};
        product_s = ext_a_s * ext_b_s;
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, opb_r};
        q_fix_s   = cond_neg(quo_r, neg_q_r);
        r_fix_s   = cond_neg(rem_r, neg_r_r);
        abs_a_s   = cond_neg(a, div_sgn_s & a[WIDTH-1]);
        abs_b_s   = cond_neg(b, div_sgn_s & b[WIDTH-1]);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_mul_s) begin
                        state_s = ST_MUL;
                    end else if (acc_div_s) begin
                        state_s = ST_DIV;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (cnt_zero_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (cnt_zero_s) begin
                        state_s = ST_FIX;
                    end else begin
                        state_s = ST_DIV;
                    end
                end
                ST_FIX:  state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: pipeline stall and the HI/LO write strobe with its data.
    always_comb begin
        stall_s = 1'b0;
        wr_s    = 1'b0;
        wr_hi_s = hi_r;
        wr_lo_s = lo_r;
        case (state_r)
            ST_IDLE: stall_s = acc_mul_s | acc_div_s;
            ST_MUL: begin
                stall_s = ~cnt_zero_s;
                if (cnt_zero_s & ~flush) begin
                    wr_s               = 1'b1;
                    {wr_hi_s, wr_lo_s} = product_s;
                end else begin
                    wr_s = 1'b0;
                end
            end
            ST_DIV:  stall_s = 1'b1;
            ST_FIX: begin
                stall_s = 1'b0;
                if (~flush) begin
                    wr_s    = 1'b1;
                    wr_hi_s = r_fix_s;
                    wr_lo_s = q_fix_s;
                end else begin
                    wr_s = 1'b0;
                end
            end
            default: stall_s = 1'b0;
        endcase
    end

    // Iteration counter: loaded on accept, counts down to the final cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (acc_mul_s) begin
            cnt_r <= CNT_MUL;
        end else if (acc_div_s) begin
            cnt_r <= CNT_DIV;
        end else if (((state_r == ST_MUL) | (state_r == ST_DIV)) & ~cnt_zero_s) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Operand latches and the divider's partial remainder / quotient shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_r   <= ZERO_W;
            opb_r   <= ZERO_W;
            sgn_r   <= 1'b0;
            rem_r   <= ZERO_W;
            quo_r   <= ZERO_W;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (acc_mul_s) begin
            opa_r <= a;
            opb_r <= b;
            sgn_r <= (op == OP_MULT);
        end else if (acc_div_s) begin
            quo_r   <= abs_a_s;
            opb_r   <= abs_b_s;
            rem_r   <= ZERO_W;
            neg_q_r <= div_sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r <= div_sgn_s & a[WIDTH-1];
        end else if (state_r == ST_DIV) begin
            // A shifted remainder at or above 2^WIDTH always exceeds the
            // divisor, so the restore branch never needs the top bit.
            if (~diff_s[WIDTH]) begin
                rem_r <= diff_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= shifted_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            rem_r <= rem_r;
        end
    end

    // HI/LO registers and the done / div_zero pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r     <= wr_s | acc_dz_s;
            div_zero_r <= acc_dz_s;
            if (wr_s) begin
                hi_r <= wr_hi_s;
                lo_r <= wr_lo_s;
            end else if (acc_mthi_s) begin
                hi_r <= a;
            end else if (acc_mtlo_s) begin
                lo_r <= a;
            end else begin
                hi_r <= hi_r;
            end
        end
    end

`ifdef MULDIV_HILO_BYPASS_EN
    // Forward the value being written this cycle onto hi/lo.
    always_comb begin
        if (wr_s) begin
            hi = wr_hi_s;
            lo = wr_lo_s;
        end else begin
            hi = acc_mthi_s ? a : hi_r;
            lo = acc_mtlo_s ? a : lo_r;
        end
    end
`else
    // hi/lo show register contents only.
    always_comb begin
        hi = hi_r;
        lo = lo_r;
    end
`endif

    assign stall    = stall_s;
    assign done     = done_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo with a result scoreboard: expected {hi,lo,div_zero}
// is queued when an operation is issued and compared when done pulses.
module tb_muldiv_hilo;
    localparam int W  = 32;
    localparam int MC = 2;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;
    localparam logic [2:0] NOP   = 3'b110;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         stall;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total  = 0;
    int   passes = 0;
    int   sc;

    always #5 clk = ~clk;

    muldiv_hilo #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .stall(stall), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic dz);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.dz = dz;
        sb.push_back(e);
    endtask

    // Issue and hold the request until stall drops; returns stalled cycles.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, output int n);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        n     = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = NOP;
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("sb_expected_done", 128'(sb.size() != 0), 128'(1'b1));
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_hi_lo_dz", 128'({hi, lo, div_zero}), 128'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = NOP; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 128'(hi), 128'(32'h0));
        chk("rst_lo", 128'(lo), 128'(32'h0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_div_zero", 128'(div_zero), 128'(1'b0));
        chk("rst_stall", 128'(stall), 128'(1'b0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Signed and unsigned multiply.
        push(32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        do_op(MULT, 32'hFFFFFFFE, 32'h00000003, sc);
        chk("mult_stall_cycles", 128'(sc), 128'(MC));
        chk("mult_done_edge", 128'(done), 128'(1'b1));
        push(32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, sc);
        chk("multu_stall_cycles", 128'(sc), 128'(MC));

        // Divides: sign combinations and the signed overflow case.
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op(DIV, 32'hFFFFFFF9, 32'h00000002, sc);
        chk("div_stall_cycles", 128'(sc), 128'(W + 1));
        chk("div_done_edge", 128'(done), 128'(1'b1));
        push(32'h00000001, 32'h00000003, 1'b0);
        do_op(DIVU, 32'h00000007, 32'h00000002, sc);
        chk("divu_stall_cycles", 128'(sc), 128'(W + 1));
        push(32'h00000001, 32'hFFFFFFFD, 1'b0);
        do_op(DIV, 32'h00000007, 32'hFFFFFFFE, sc);
        push(32'h00000000, 32'h80000000, 1'b0);
        do_op(DIV, 32'h80000000, 32'hFFFFFFFF, sc);

        // MTHI / MTLO, then divide by zero.
        do_op(MTHI, 32'h00000011, 32'h0, sc);
        chk("mthi_no_stall", 128'(sc), 128'(0));
        chk("mthi_hi", 128'(hi), 128'(32'h11));
        do_op(MTLO, 32'h00000022, 32'h0, sc);
        chk("mtlo_lo", 128'(lo), 128'(32'h22));
        chk("mtlo_hi_kept", 128'(hi), 128'(32'h11));
        push(32'h00000011, 32'h00000022, 1'b1);
        do_op(DIV, 32'h00000005, 32'h0, sc);
        chk("dz_no_stall", 128'(sc), 128'(0));
        chk("dz_done", 128'(done), 128'(1'b1));
        chk("dz_flag", 128'(div_zero), 128'(1'b1));

        // Flush mid-divide, then MTLO accepted right after.
        start = 1'b1; op = DIV; a = 32'd100; b = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b0; op = NOP;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle_stall", 128'(stall), 128'(1'b0));
        chk("flush_no_done", 128'(done), 128'(1'b0));
        chk("flush_hi_kept", 128'(hi), 128'(32'h11));
        chk("flush_lo_kept", 128'(lo), 128'(32'h22));
        do_op(MTLO, 32'h0000005A, 32'h0, sc);
        chk("post_flush_mtlo", 128'(lo), 128'(32'h5A));

        // Flush in the final multiply cycle suppresses the write.
        start = 1'b1; op = MULTU; a = 32'd2; b = 32'd2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) break;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0; op = NOP;
        chk("final_flush_no_done", 128'(done), 128'(1'b0));
        chk("final_flush_lo_kept", 128'(lo), 128'(32'h5A));
        chk("final_flush_hi_kept", 128'(hi), 128'(32'h11));

        // A different request presented while dividing is ignored.
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        op = MTHI; a = 32'h0000DEAD;
        push(32'h00000002, 32'h0000000E, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
        end
        @(posedge clk);
        #1;
        start = 1'b0; op = NOP;
        chk("busy_start_done", 128'(done), 128'(1'b1));
        chk("busy_start_hi", 128'(hi), 128'(32'h2));
        chk("busy_start_lo", 128'(lo), 128'(32'hE));

        // Reset during a multiply, then recovery.
        start = 1'b1; op = MULT; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0; op = NOP;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mul_hi", 128'(hi), 128'(32'h0));
        chk("rst_mul_lo", 128'(lo), 128'(32'h0));
        chk("rst_mul_stall", 128'(stall), 128'(1'b0));
        chk("rst_mul_done", 128'(done), 128'(1'b0));
        push(32'h00000000, 32'h0000000F, 1'b0);
        do_op(MULT, 32'd3, 32'd5, sc);
        chk("post_rst_mult_stall", 128'(sc), 128'(MC));

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits in the execute stage beside the ALU. The control decoder issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a 3-bit op; MFHI/MFLO read hi/lo directly.
- Parametrised in operand width and multiply latency.
- Stalls the pipeline while an operation is in flight and supports abort on exception flush.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_CYCLES, 2, cycles from accepted multiply to HI/LO write; legal range 1..8.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  issue request, sampled each edge
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x NOP
- a  input  WIDTH  rs operand: dividend/multiplicand, or MTHI/MTLO data
- b  input  WIDTH  rt operand: divisor/multiplier
- flush  input  1  abort in-flight operation and ignore start this cycle
- stall  output  1  combinational; high while the pipeline must hold
- done  output  1  one-cycle pulse on the edge at which HI/LO are written by mul/div
- div_zero  output  1  one-cycle pulse with done when a DIV/DIVU had b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: hi=0, lo=0, done=0, div_zero=0, state IDLE, counter=0. rst wins over start and flush.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start & !flush & op=MTHI: hi<=a at next edge; lo unchanged; no stall; stay IDLE.
  - MTLO is symmetric (lo<=a).
  - start & !flush & op in {MULT, MULTU}: latch a, b and signedness; counter<=MUL_CYCLES-1; go to MUL.
  - start & !flush & op in {DIV, DIVU}:
    - If b==0: hi/lo unchanged; done=1 and div_zero=1 on the next edge; stay IDLE.
    - Otherwise: latch |a| and |b| (signed ops) or raw values (unsigned); record quotient and remainder signs; counter<=WIDTH-1; go to DIV.
  - start with NOP op: no effect.
- MUL:
  - Product is the 2*WIDTH-bit signed or unsigned product of the latched operands.
  - When counter==0: {hi,lo}<=product, done=1, go to IDLE. Otherwise decrement the counter.
  - Total: start sampled at edge N, HI/LO written at edge N+MUL_CYCLES.
- DIV:
  - One restoring shift-subtract iteration per cycle on a WIDTH+1-bit partial remainder.
  - After WIDTH iterations, go to FIX.
- FIX (one cycle):
  - Negate quotient if sign(a)!=sign(b); negate remainder if a was negative.
  - lo<=quotient, hi<=remainder, done=1, go to IDLE.
  - Division latency is WIDTH+1 cycles after acceptance.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case -2^(W-1)/-1 yields lo=0x80000000, hi=0 for W=32. No trap.
- stall:
  - High when (state!=IDLE and not in the final cycle, i.e. MUL with counter==0 or FIX).
  - Also high when (state==IDLE & start & !flush & op is MULT/MULTU/DIV/DIVU with b!=0 for div).
  - The issuing instruction therefore holds until the result cycle.
  - stall is low during the final cycle, so a dependent MFHI/MFLO in the next cycle reads new values.
- start while state!=IDLE: ignored; the issuer is stalled and must hold the request.
- flush:
  - In any state: go to IDLE at next edge; hi/lo not written; done=0.
  - flush asserted in the final MUL/FIX cycle also suppresses the write.
- done and div_zero are registered, default 0 each cycle.

Optional Feature:
- Macro: MULDIV_HILO_BYPASS_EN.
- Defined: hi/lo outputs are combinational forwards.
  - During an accepted MTHI/MTLO cycle, the corresponding output shows a.
  - During the final MUL/FIX cycle (when not flushed), hi/lo show the value about to be written.
- Not defined: hi/lo reflect register contents only; new values are visible one cycle after the write edge.

Test Plan:
- MULT 32-bit: a=0xFFFFFFFE (-2), b=3, MUL_CYCLES=2 -> stall high 2 cycles; done at edge N+2; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV signed: a=-7 (0xFFFFFFF9), b=2 -> done after 33 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- Divide by zero: hi=0x11, lo=0x22 preset via MTHI/MTLO; DIV a=5, b=0 -> done and div_zero pulse next edge, no stall, hi/lo unchanged.
- Flush mid-divide at cycle 10 -> state IDLE next edge, no done, hi/lo unchanged; new MTLO a=0x5A accepted next cycle -> lo=0x5A.
- Reset mid-multiply and start-while-busy: second start during DIV ignored; rst during MUL -> hi=lo=0, stall=0 next cycle.
